boot_select: RTL and testbench
==============================

# boot_select

Boot-image selector that drives the iCE40 warm-boot primitive in the first-stage boot image. It synchronises and debounces the user button, waits a fixed hold-off window after reset, and decides between the DFU bootloader slot and the user-application slot. It then presents a stable image number and a sticky boot request directly to `SB_WARMBOOT` (`S1`/`S0` from `image_sel`, `BOOT` from `boot`).

## Interface
- `DELAY_CYCLES`, default 255: hold-off window length in `pin_clk` cycles before the decision.
- `DEBOUNCE_BITS`, default 4: the debounced level changes only after 2^`DEBOUNCE_BITS` consecutive disagreeing cycles.
- `DFU_IMAGE`, default 2'b01: slot selected when DFU is requested.
- `APP_IMAGE`, default 2'b10: slot selected otherwise.
- `pin_clk`  in  1: sole clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `pin_button`  in  1: raw button, active-low, asynchronous to `pin_clk`.
- `force_dfu`  in  1: synchronous request from fabric logic; a 1-cycle pulse suffices.
- `image_sel`  out  2: warm-boot slot number, wired to `{S1,S0}`.
- `boot`  out  1: warm-boot trigger, wired to `BOOT`.
- `dfu_pending`  out  1: sticky DFU-request flag, used for LED feedback.

## Operation
- **Synchroniser:** `pin_button` passes through a 2-FF synchroniser, then is inverted to give `btn_sync` (1 = pressed). Both flops reset to 1 (released).
- **Debounce counter:** a `DEBOUNCE_BITS`-wide counter clears whenever `btn_sync` equals `btn_db`.
  - While they differ, the counter increments.
  - When it reaches all-ones while still differing, `btn_db` takes `btn_sync` and the counter clears.
  - `btn_db` resets to 0.
- **FSM:** three states, `S_DELAY`, `S_ARM` and `S_BOOT`; the reset state is `S_DELAY`.
  - **`S_DELAY`:** `dly_cnt` loads `DELAY_CYCLES` on reset.
    - While `dly_cnt != 0`, `dly_cnt` decrements.
    - `dfu_pending` sets whenever `btn_db | force_dfu` is 1, and stays set.
    - When `dly_cnt == 0`, go to `S_ARM`. On that same edge, `image_sel` is loaded with `(dfu_pending | btn_db | force_dfu) ? DFU_IMAGE : APP_IMAGE`.
  - **`S_ARM`:** `image_sel` is held; next edge goes to `S_BOOT` and sets `boot`.
  - **`S_BOOT`:** terminal state. `boot` = 1 and `image_sel` is frozen until `rst`.
- **Freeze after decision:** `dfu_pending`, `image_sel` and `boot` ignore the button and `force_dfu` once the FSM has left `S_DELAY`.
- **Reset values:** `image_sel` = `APP_IMAGE`, `boot` = 0, `dfu_pending` = 0, `dly_cnt` = `DELAY_CYCLES`.
- **Width rules:**
  - `dly_cnt` is `$clog2(DELAY_CYCLES+1)` bits wide, with a minimum of 1 bit.
  - The debounce counter saturates only through its clear. It never wraps while `btn_sync != btn_db`, because reaching all-ones forces the update.

## Timing
- Edge 1 is the first rising `pin_clk` edge after `rst` deasserts.
  - `S_ARM` is entered on edge `DELAY_CYCLES+1`.
  - `boot` rises on edge `DELAY_CYCLES+2`.
- **Setup guarantee:** `image_sel` is stable for at least one full cycle before `boot` rises.
- **Button latency:** a press is recognised 2 (sync) + 2^`DEBOUNCE_BITS` cycles after the pin edge. A press must satisfy this by edge `DELAY_CYCLES+1` to select DFU.
- **`force_dfu` latency:** takes effect in the same cycle. A pulse coincident with the `dly_cnt == 0` cycle still selects DFU.
- **`DELAY_CYCLES` = 0:** `S_ARM` on edge 1, `boot` on edge 2.
- **Bounce:** glitches shorter than 2^`DEBOUNCE_BITS` cycles never change `btn_db` or `dfu_pending`.
- **Reset during operation:** `rst` asserted in any state, including `S_BOOT`, immediately clears all outputs to reset values. The full delay restarts on release.

## Structure
- Package `boot_pkg` holds:
  - the state enum `boot_state_t` (`S_DELAY`, `S_ARM`, `S_BOOT`);
  - the slot constants `SLOT_SELF`=0, `SLOT_DFU`=1, `SLOT_APP`=2, which are the defaults for `DFU_IMAGE` and `APP_IMAGE`.
- Sub-module `button_debounce` contains the synchroniser and the debounce counter.
  - Parameter: `DEBOUNCE_BITS`.
  - Ports: `pin_clk`, `rst`, `pin_button`, `btn_db`.
- The FSM and delay counter stay in `boot_select`.

## Test plan
- Button released, `force_dfu` = 0, defaults: `boot` rises on edge 257 with `image_sel` = 2'b10; `dfu_pending` stays 0.
- Button held low from reset: `btn_db` = 1 by edge 18 and `dfu_pending` = 1. `image_sel` = 2'b01 on edge 256, and is stable when `boot` rises on edge 257.
- 10-cycle low glitches every 40 cycles with `DEBOUNCE_BITS` = 4: `btn_db` never rises, and the result is `APP_IMAGE`.
- `force_dfu` 1-cycle pulse at edge 256 (the `dly_cnt == 0` cycle): `image_sel` = 2'b01. The same pulse at edge 258 causes no change.
- `rst` pulsed at edge 300 while in `S_BOOT`: `boot` = 0 and `image_sel` = 2'b10 immediately (asynchronously); `boot` rises again 257 edges after release.
- `DELAY_CYCLES` = 0: `boot` = 1 on edge 2 with `image_sel` = `APP_IMAGE`. With `force_dfu` high on edge 1, `image_sel` = `DFU_IMAGE` instead.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared state encoding and warm-boot slot numbers for the first-stage boot selector.
package boot_pkg;

    typedef enum logic [1:0] {
        S_DELAY = 2'd0,
        S_ARM   = 2'd1,
        S_BOOT  = 2'd2
    } boot_state_t;

    localparam logic [1:0] SLOT_SELF = 2'd0;
    localparam logic [1:0] SLOT_DFU  = 2'd1;
    localparam logic [1:0] SLOT_APP  = 2'd2;

endpackage

// File: rtl/boot_select_button_debounce.sv
// Two-flop synchroniser and saturating-by-clear debounce for the active-low user button.
module button_debounce #(
    parameter int DEBOUNCE_BITS = 4
) (
    input  logic pin_clk,
    input  logic rst,
    input  logic pin_button,
    output logic btn_db
);

    logic                     sync_1;
    logic                     sync_2;
    logic                     btn_sync;
    logic [DEBOUNCE_BITS-1:0] db_cnt;

    always_ff @(posedge pin_clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= pin_button;
            sync_2 <= sync_1;
        end
    end

    assign btn_sync = ~sync_2;

    // Reaching all-ones while still disagreeing forces the update, so the counter never wraps.
    always_ff @(posedge pin_clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_sync == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == {DEBOUNCE_BITS{1'b1}}) begin
            db_cnt <= '0;
            btn_db <= btn_sync;
        end else begin
            db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
        end
    end

endmodule

// File: rtl/boot_select.sv
// Boot-image selector: waits a hold-off window, picks DFU or application slot,
// then raises a sticky warm-boot request with the slot number already stable.
//
// state   | meaning
// S_DELAY | hold-off countdown, collecting DFU requests
// S_ARM   | slot decided, one settle cycle before boot
// S_BOOT  | boot asserted, everything frozen until reset
module boot_select
    import boot_pkg::*;
#(
    parameter int         DELAY_CYCLES  = 255,
    parameter int         DEBOUNCE_BITS = 4,
    parameter logic [1:0] DFU_IMAGE     = SLOT_DFU,
    parameter logic [1:0] APP_IMAGE     = SLOT_APP
) (
    input  logic       pin_clk,
    input  logic       rst,
    input  logic       pin_button,
    input  logic       force_dfu,
    output logic [1:0] image_sel,
    output logic       boot,
    output logic       dfu_pending
);

    localparam int            DW       = (DELAY_CYCLES < 1) ? 1 : $clog2(DELAY_CYCLES + 1);
    localparam logic [DW-1:0] DLY_INIT = DW'(DELAY_CYCLES);

    boot_state_t   state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [1:0]    image_d;
    logic          boot_d;
    logic          pend_d;
    logic          btn_db;

    button_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_debounce (
        .pin_clk    (pin_clk),
        .rst        (rst),
        .pin_button (pin_button),
        .btn_db     (btn_db)
    );

    always_ff @(posedge pin_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_DELAY;
            dly_q       <= DLY_INIT;
            image_sel   <= APP_IMAGE;
            boot        <= 1'b0;
            dfu_pending <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            image_sel   <= image_d;
            boot        <= boot_d;
            dfu_pending <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        image_d = image_sel;
        boot_d  = boot;
        pend_d  = dfu_pending;
        case (state_q)
            S_DELAY: begin
                if (btn_db || force_dfu) pend_d = 1'b1;
                if (dly_q != '0) begin
                    dly_d = dly_q - DW'(1);
                end else begin
                    // A request arriving in this very cycle still counts.
                    state_d = S_ARM;
                    image_d = (dfu_pending || btn_db || force_dfu) ? DFU_IMAGE : APP_IMAGE;
                end
            end
            S_ARM: begin
                state_d = S_BOOT;
                boot_d  = 1'b1;
            end
            S_BOOT: begin
                boot_d = 1'b1;
            end
            default: begin
                state_d = S_DELAY;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_select.sv
// Directed bench for boot_select: vector table of boot scenarios plus reset and zero-delay sequences.
module tb_boot_select;

    logic       clk = 1'b0;
    logic       rst, pin_button, force_dfu;
    logic [1:0] image_sel;
    logic       boot, dfu_pending;

    logic       rst0, force0;
    logic [1:0] image_sel0;
    logic       boot0, dfu_pending0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    boot_select dut (
        .pin_clk     (clk),
        .rst         (rst),
        .pin_button  (pin_button),
        .force_dfu   (force_dfu),
        .image_sel   (image_sel),
        .boot        (boot),
        .dfu_pending (dfu_pending)
    );

    boot_select #(.DELAY_CYCLES(0)) dut0 (
        .pin_clk     (clk),
        .rst         (rst0),
        .pin_button  (1'b1),
        .force_dfu   (force0),
        .image_sel   (image_sel0),
        .boot        (boot0),
        .dfu_pending (dfu_pending0)
    );

    typedef struct {
        string      name;
        int         hold_from;   // button low for edges > hold_from; -1 = never
        int         force_edge;  // edge at which force_dfu is sampled high; -1 = never
        bit         glitch;      // 10-cycle low glitches every 40 cycles
        logic [1:0] exp_image;
        logic       exp_pend;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_main(input logic pin_during_reset);
        rst        = 1'b1;
        force_dfu  = 1'b0;
        pin_button = pin_during_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"idle",        -1,  -1, 1'b0, 2'b10, 1'b0};
        vecs[1] = '{"held",         0,  -1, 1'b0, 2'b01, 1'b1};
        vecs[2] = '{"glitch",      -1,  -1, 1'b1, 2'b10, 1'b0};
        vecs[3] = '{"force256",    -1, 256, 1'b0, 2'b01, 1'b1};
        vecs[4] = '{"force258",    -1, 258, 1'b0, 2'b10, 1'b0};
        vecs[5] = '{"force100",    -1, 100, 1'b0, 2'b01, 1'b1};
        vecs[6] = '{"press_early", 237,  -1, 1'b0, 2'b01, 1'b1};
        vecs[7] = '{"press_late",  240,  -1, 1'b0, 2'b10, 1'b0};

        rst0   = 1'b1;
        force0 = 1'b0;

        for (int v = 0; v < 8; v++) begin
            reset_main(vecs[v].hold_from == 0 ? 1'b0 : 1'b1);
            check({vecs[v].name, "_rst_image"}, image_sel, 2'b10);
            check({vecs[v].name, "_rst_boot"}, {1'b0, boot}, 2'b00);
            for (int k = 1; k <= 260; k++) begin
                if (vecs[v].hold_from >= 0 && k > vecs[v].hold_from)
                    pin_button = 1'b0;
                else if (vecs[v].glitch && (k % 40) >= 20 && (k % 40) < 30)
                    pin_button = 1'b0;
                else
                    pin_button = 1'b1;
                force_dfu = (k == vecs[v].force_edge);
                @(posedge clk);
                #1;
                if (v == 1 && k == 18) check("held_pend_e18", {1'b0, dfu_pending}, 2'b00);
                if (v == 1 && k == 19) check("held_pend_e19", {1'b0, dfu_pending}, 2'b01);
                if (k == 255) check({vecs[v].name, "_img_e255"}, image_sel, 2'b10);
                if (k == 256) begin
                    check({vecs[v].name, "_img_e256"}, image_sel, vecs[v].exp_image);
                    check({vecs[v].name, "_boot_e256"}, {1'b0, boot}, 2'b00);
                end
                if (k == 257) begin
                    check({vecs[v].name, "_boot_e257"}, {1'b0, boot}, 2'b01);
                    check({vecs[v].name, "_img_e257"}, image_sel, vecs[v].exp_image);
                end
            end
            check({vecs[v].name, "_img_end"}, image_sel, vecs[v].exp_image);
            check({vecs[v].name, "_pend_end"}, {1'b0, dfu_pending}, {1'b0, vecs[v].exp_pend});
            check({vecs[v].name, "_boot_end"}, {1'b0, boot}, 2'b01);
        end

        // Reset while in S_BOOT with DFU selected: outputs clear asynchronously.
        reset_main(1'b0);
        repeat (299) @(posedge clk);
        @(posedge clk);
        #3;
        check("async_pre_image", image_sel, 2'b01);
        rst = 1'b1;
        #1;
        check("async_boot", {1'b0, boot}, 2'b00);
        check("async_image", image_sel, 2'b10);
        check("async_pend", {1'b0, dfu_pending}, 2'b00);
        pin_button = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 257; k++) begin
            @(posedge clk);
            #1;
            if (k == 256) check("rerun_boot_e256", {1'b0, boot}, 2'b00);
            if (k == 257) begin
                check("rerun_boot_e257", {1'b0, boot}, 2'b01);
                check("rerun_image", image_sel, 2'b10);
            end
        end

        // Zero hold-off: decision on edge 1, boot on edge 2.
        for (int f = 0; f < 2; f++) begin
            rst0   = 1'b1;
            force0 = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst0   = 1'b0;
            force0 = (f == 1);
            @(posedge clk);
            #1;
            force0 = 1'b0;
            check(f ? "d0f_boot_e1" : "d0_boot_e1", {1'b0, boot0}, 2'b00);
            check(f ? "d0f_img_e1" : "d0_img_e1", image_sel0, f ? 2'b01 : 2'b10);
            @(posedge clk);
            #1;
            check(f ? "d0f_boot_e2" : "d0_boot_e2", {1'b0, boot0}, 2'b01);
            check(f ? "d0f_img_e2" : "d0_img_e2", image_sel0, f ? 2'b01 : 2'b10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
